// File: rtl/i2c_bridge_pkg.sv
// ---------------------------------------------------------------------------
// i2c_bridge_pkg
// Shared constants and types for the I2C bridge front end and slave engine.
//   I2C_SYNC_STAGES    : default synchroniser depth per line
//   I2C_FILT_LEN       : default glitch-filter stability length (cycles)
//   I2C_TIMEOUT_CYCLES : default SCL-low timeout (25 ms at 50 MHz)
//   i2c_bus_event_e    : bus events handed to the slave engine
// ---------------------------------------------------------------------------
package i2c_bridge_pkg;

    localparam int I2C_SYNC_STAGES    = 2;
    localparam int I2C_FILT_LEN       = 3;
    localparam int I2C_TIMEOUT_CYCLES = 1250000;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_START = 2'd1,
        EV_STOP  = 2'd2
    } i2c_bus_event_e;

endpackage

// File: rtl/i2c_bus_conditioner_if.sv
// ---------------------------------------------------------------------------
// i2c_bus_conditioner_if
// Groups the raw I2C pins and the conditioned levels/strobes.
//   scl_in, sda_in          : raw pins (driven by the pad side)
//   scl_f, sda_f            : filtered levels
//   scl_rise, scl_fall      : one-cycle filtered SCL edge strobes
//   start_det, stop_det     : one-cycle START / STOP strobes
//   bus_busy, bus_stuck     : bus state flags
// Modports:
//   slave  : the conditioner (consumes pins, produces strobes)
//   master : pad/engine side (drives pins, consumes strobes)
// Handshake: there is no flow control; every strobe is a single-cycle
// pulse, valid for exactly one clk cycle and must be consumed in that cycle.
// ---------------------------------------------------------------------------
interface i2c_bus_conditioner_if;

    logic scl_in;
    logic sda_in;
    logic scl_f;
    logic sda_f;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic bus_busy;
    logic bus_stuck;

    modport slave (
        input  scl_in, sda_in,
        output scl_f, sda_f, scl_rise, scl_fall,
               start_det, stop_det, bus_busy, bus_stuck
    );

    modport master (
        output scl_in, sda_in,
        input  scl_f, sda_f, scl_rise, scl_fall,
               start_det, stop_det, bus_busy, bus_stuck
    );

endinterface

// File: rtl/i2c_glitch_filter.sv
// ---------------------------------------------------------------------------
// i2c_glitch_filter
// Synchroniser chain followed by a stability counter for one I2C line.
// The filtered level follows the synced level only after it has differed
// for FILT_LEN consecutive cycles; total latency is SYNC_STAGES+FILT_LEN.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   pin       : raw asynchronous line
//   level     : filtered level (resets to 1, idle bus)
//   rise/fall : registered one-cycle pulses, coincident with level change
//   flip      : combinational "level changes on this edge" (for the top's
//               START/STOP decode, which must see both lines' updates)
// ---------------------------------------------------------------------------
module i2c_glitch_filter
    import i2c_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = I2C_SYNC_STAGES,
    parameter int FILT_LEN    = I2C_FILT_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall,
    output logic flip
);

    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign flip   = (synced != level) && (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            level  <= 1'b1;
            cnt_q  <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            rise   <= flip & synced;
            fall   <= flip & ~synced;
            if (synced == level) begin
                cnt_q <= '0;
            end else if (flip) begin
                level <= synced;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// ---------------------------------------------------------------------------
// i2c_bus_conditioner
// Front end between raw I2C slave pins and the slave engine: filters both
// lines and decodes SCL edges, START, STOP and bus-busy.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : i2c_bus_conditioner_if.slave (pins in, levels/strobes out)
// Optional build macro I2C_TIMEOUT_EN: adds a stuck-SCL timeout that sets
// bus_stuck and force-clears bus_busy; without it bus_stuck is tied to 0.
// ---------------------------------------------------------------------------
module i2c_bus_conditioner
    import i2c_bridge_pkg::*;
#(
    parameter int SYNC_STAGES    = I2C_SYNC_STAGES,
    parameter int FILT_LEN       = I2C_FILT_LEN,
    parameter int TIMEOUT_CYCLES = I2C_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_bus_conditioner_if.slave  bus
);

    logic scl_f, sda_f, scl_flip, sda_flip;
    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_cond, stop_cond;
    logic start_q, stop_q, busy_q;

    i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clk), .rst(rst), .pin(bus.scl_in),
        .level(scl_f), .rise(scl_rise), .fall(scl_fall), .flip(scl_flip)
    );

    i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clk), .rst(rst), .pin(bus.sda_in),
        .level(sda_f), .rise(sda_rise), .fall(sda_fall), .flip(sda_flip)
    );

    // SDA edge qualifies only if SCL is high now and is not changing on this
    // same edge, so a simultaneous SCL/SDA change reports neither event.
    assign start_cond = sda_flip &  sda_f & scl_f & ~scl_flip;
    assign stop_cond  = sda_flip & ~sda_f & scl_f & ~scl_flip;

`ifdef I2C_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_q;
    logic            stuck_q;
    logic            timeout_hit;

    assign timeout_hit = busy_q & ~scl_f & ~stuck_q & (to_cnt_q == TO_MAX - 1'b1);

    // Counter holds its saturated value while stuck; busy is already cleared
    // then, so the idle-clear must not apply until SCL recovers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
            stuck_q  <= 1'b0;
        end else begin
            if (scl_f) begin
                to_cnt_q <= '0;
            end else if (stuck_q) begin
                to_cnt_q <= to_cnt_q;
            end else if (!busy_q) begin
                to_cnt_q <= '0;
            end else if (to_cnt_q != TO_MAX) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (scl_flip & ~scl_f) begin
                stuck_q <= 1'b0;
            end else if (timeout_hit) begin
                stuck_q <= 1'b1;
            end
        end
    end

    assign bus.bus_stuck = stuck_q;
`else
    assign bus.bus_stuck = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            start_q <= start_cond;
            stop_q  <= stop_cond;
            if (start_cond) begin
                busy_q <= 1'b1;
            end else if (stop_cond) begin
                busy_q <= 1'b0;
            end
`ifdef I2C_TIMEOUT_EN
            else if (timeout_hit) begin
                busy_q <= 1'b0;
            end
`endif
        end
    end

    assign bus.scl_f     = scl_f;
    assign bus.sda_f     = sda_f;
    assign bus.scl_rise  = scl_rise;
    assign bus.scl_fall  = scl_fall;
    assign bus.start_det = start_q;
    assign bus.stop_det  = stop_q;
    assign bus.bus_busy  = busy_q;

    // SDA edge strobes are not part of the external interface.
    logic unused_sda_edges;
    assign unused_sda_edges = sda_rise ^ sda_fall;

endmodule

// File: doc/i2c_bus_conditioner.md
Name: i2c_bus_conditioner

Overview:
- Front-end stage between the raw I2C slave pins (SCL on ui_in[0], SDA on uio_in[0]) and the bridge's I2C slave engine.
- Synchronises both lines to clk and rejects glitches with a digital stability filter.
- Produces clean levels plus single-cycle SCL edge, START and STOP strobes, and a bus-busy flag.
- The slave engine consumes these strobes instead of sampling the pins directly.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops per line (legal range ≥2).
- FILT_LEN, 3, consecutive cycles a synced level must persist before the filtered output follows it (legal range ≥1).
- TIMEOUT_CYCLES, 1250000, SCL-low cycles while busy before a stuck bus is declared (25 ms at 50 MHz); used only with I2C_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- scl_in  in  1  raw SCL pin
- sda_in  in  1  raw SDA pin
- scl_f  out  1  filtered SCL level
- sda_f  out  1  filtered SDA level
- scl_rise  out  1  one-cycle pulse on filtered SCL 0→1
- scl_fall  out  1  one-cycle pulse on filtered SCL 1→0
- start_det  out  1  one-cycle pulse on START or repeated START
- stop_det  out  1  one-cycle pulse on STOP
- bus_busy  out  1  high from START until STOP
- bus_stuck  out  1  SCL held low too long; constant 0 when the feature is not compiled in

Behaviour:
- Reset values:
  - Synchroniser flops: 1 (idle-high bus).
  - scl_f, sda_f: 1.
  - Filter counters: 0.
  - All pulse outputs, bus_busy, bus_stuck: 0.
  - Reset asserted mid-transaction returns everything to these values immediately.
  - After release, no spurious edge, START or STOP pulse is generated.
- Filter, per line:
  - If the synced value equals the filtered value, the counter clears.
  - Otherwise the counter increments. When it reaches FILT_LEN-1 and the synced value still differs, the filtered value flips on that clock and the counter clears.
  - A pulse shorter than FILT_LEN synced cycles never reaches the output.
- Latency: the filtered output changes exactly SYNC_STAGES+FILT_LEN rising edges after the first edge that samples the new pin level (5 with defaults).
- Pulses are registered and asserted in the same cycle the filtered value takes its new level; width is always one cycle.
- scl_rise / scl_fall: asserted on filtered SCL transitions.
- start_det: filtered SDA 1→0 while filtered SCL is 1 both before and after that update.
- stop_det: filtered SDA 0→1 under the same SCL condition.
- Simultaneous SCL and SDA filtered change in one cycle:
  - Neither START nor STOP is reported.
  - The SCL edge pulse is still reported.
- bus_busy:
  - Set on start_det.
  - Cleared on stop_det.
  - A repeated START while busy pulses start_det and keeps bus_busy at 1.
  - STOP while idle pulses stop_det and leaves bus_busy at 0.

Optional Feature:
- Macro: I2C_TIMEOUT_EN.
- Defined:
  - A ceil(log2(TIMEOUT_CYCLES+1))-bit counter increments while bus_busy=1 and scl_f=0, and clears whenever scl_f=1 or bus_busy=0.
  - On reaching TIMEOUT_CYCLES: bus_stuck is set, bus_busy is force-cleared, and the counter saturates.
  - bus_stuck is sticky until scl_f next rises.
- Not defined: no counter is built and bus_stuck is tied to 0.

Decomposition:
- Shared package i2c_bridge_pkg holds:
  - Default constants I2C_SYNC_STAGES=2, I2C_FILT_LEN=3, I2C_TIMEOUT_CYCLES.
  - An enum of bus events (EV_NONE, EV_START, EV_STOP) for the slave engine.
- One natural sub-module, i2c_glitch_filter (synchroniser + stability counter + filtered level + rise/fall pulses), instantiated once for SCL and once for SDA.
- START/STOP/busy/timeout logic stays in the top.

Test Plan:
- Reset with both pins low, release with pins high: scl_f=sda_f=1 throughout, zero pulses emitted.
- SCL pin 1→0 held: scl_f falls exactly 5 edges later with a one-cycle scl_fall; pin held low for only 2 cycles: no change, no pulse.
- SCL high, SDA 1→0 then SCL 1→0: start_det one cycle, bus_busy=1; SCL 0→1 then SDA 0→1: stop_det one cycle, bus_busy=0.
- Busy bus, SCL high, SDA 1→0 again: second start_det, bus_busy stays 1; SCL and SDA falling on the same clock: only scl_fall pulses.
- I2C_TIMEOUT_EN with TIMEOUT_CYCLES=100: START, then SCL held low 100 cycles: bus_stuck=1, bus_busy=0; SCL released: bus_stuck clears 5 cycles later.
- rst asserted mid-byte with SCL low: all outputs at reset values asynchronously; after release with pins high, no pulses.
